c1541_flux_shifter: RTL and testbench

//  Read/write electronics of the 1541 drive, downstream of the track buffer.
//  - Read path: recovers bit cells from the track's flux pulse stream; detects SYNC (10 consecutive 1s); assembles GCR bytes for the VIA.
//  - Write path: serialises VIA bytes into flux pulses and the write-enable returned to the track buffer.

---
 rtl/c1541_pkg.sv | 13 +
 rtl/c1541_bit_clock.sv | 54 +++++
 rtl/c1541_flux_shifter.sv | 136 +++++++++++++
 tb/tb_c1541_flux_shifter.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/c1541_pkg.sv
// Shared types and helpers for the 1541 flux shifter.
// cell_div gives 16 MHz reference cycles per bit-clock tick for a speed zone.
package c1541_pkg;

  localparam int SYNC_BITS = 10;

  typedef logic [1:0] zone_t;

  function automatic logic [4:0] cell_div(input zone_t z);
    return 5'd16 - {3'b000, z};
  endfunction

endpackage

// File: rtl/c1541_bit_clock.sv
// Bit-cell clock: prescaler plus 2-bit phase, 4 ticks per cell, resynced by read flux edges.
// bit_strobe is combinational on the phase 1->2 tick; everything holds while mtr=0.
module c1541_bit_clock
  import c1541_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       mtr,
  input  logic [1:0] zone,
  input  logic       resync,
  output logic       tick,
  output logic       bit_strobe,
  output logic [1:0] phase
);

  localparam int PW = $clog2(CLK_DIV * 16);

  logic [PW-1:0] presc;
  logic [PW-1:0] presc_max;
  zone_t         zone_q;
  zone_t         zone_cur;

  // The zone is sampled at the start of every prescaler period, so a change lands on the next wrap.
  always_comb begin
    zone_cur  = (presc == '0) ? zone : zone_q;
    presc_max = PW'(CLK_DIV * int'(cell_div(zone_cur)) - 1);
  end

  assign tick       = mtr & (presc == presc_max);
  assign bit_strobe = tick & (phase == 2'd1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc  <= '0;
      phase  <= '0;
      zone_q <= '0;
    end else if (mtr) begin
      if (presc == '0)
        zone_q <= zone;
      if (resync) begin
        presc <= '0;
        phase <= '0;
      end else if (tick) begin
        presc <= '0;
        phase <= phase + 2'd1;
      end else begin
        presc <= presc + 1'b1;
      end
    end
  end

endmodule

// File: rtl/c1541_flux_shifter.sv
// 1541 read/write shifter: flux to GCR bytes with SYNC detect, and bytes to write flux; byte_out lands on the bit that completes it.
// Write path only when C1541_WRITE_EN is defined; otherwise mode is ignored and the block always reads.
module c1541_flux_shifter
  import c1541_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int BR_LEN  = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       mtr,
  input  logic [1:0] zone,
  input  logic       mode,
  input  logic       soe,
  input  logic       flux,
  input  logic [7:0] din_byte,
  output logic [7:0] byte_out,
  output logic       byte_ready_n,
  output logic       sync_n,
  output logic       buff_din,
  output logic       buff_we
);

  localparam int BRW = $clog2(BR_LEN + 1);

  logic                 flux_d;
  logic                 flux_seen;
  logic                 rd_mode;
  logic                 mode_chg;
  logic                 resync;
  logic                 bit_strobe;
  logic                 tick_unused;
  logic [1:0]           phase;
  logic                 emit_bit;
  logic [SYNC_BITS-1:0] read_sr;
  logic [SYNC_BITS-1:0] sr_next;
  logic                 sync_hit;
  logic                 cnt_wrap;
  logic [2:0]           bit_cnt;
  logic [BRW-1:0]       br_cnt;

  c1541_bit_clock #(.CLK_DIV(CLK_DIV)) u_bit_clock (
    .clk        (clk),
    .reset      (reset),
    .mtr        (mtr),
    .zone       (zone),
    .resync     (resync),
    .tick       (tick_unused),
    .bit_strobe (bit_strobe),
    .phase      (phase)
  );

  assign resync   = mtr & rd_mode & flux & ~flux_d;
  assign sr_next  = {read_sr[SYNC_BITS-2:0], emit_bit};
  assign sync_hit = (sr_next == '1);
  // A bit lost to a mode switch never counts toward a byte.
  assign cnt_wrap = bit_strobe & ~mode_chg & (bit_cnt == 3'd7) & ~(rd_mode & sync_hit);
  assign byte_ready_n = (br_cnt == '0);

`ifdef C1541_WRITE_EN
  logic       mode_d;
  logic       out_bit;
  logic [7:0] write_sr;
  logic [7:0] wr_word;

  assign rd_mode  = mode;
  assign mode_chg = mode ^ mode_d;
  assign wr_word  = (bit_cnt == 3'd0) ? din_byte : write_sr;
  assign emit_bit = mode ? flux_seen : wr_word[7];
  assign buff_we  = mtr & ~mode;
  // Phases 2 and 3 are exactly the two ticks after the emitting tick.
  assign buff_din = buff_we & out_bit & phase[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_d   <= 1'b1;
      out_bit  <= 1'b0;
      write_sr <= '0;
    end else begin
      mode_d <= mode;
      if (mode_chg) begin
        out_bit <= 1'b0;
      end else if (bit_strobe & ~mode) begin
        out_bit  <= wr_word[7];
        write_sr <= {wr_word[6:0], 1'b0};
      end
    end
  end
`else
  logic unused_inputs;

  assign rd_mode       = 1'b1;
  assign mode_chg      = 1'b0;
  assign emit_bit      = flux_seen;
  assign buff_we       = 1'b0;
  assign buff_din      = 1'b0;
  assign unused_inputs = &{1'b0, mode, din_byte, phase};
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flux_d    <= 1'b0;
      flux_seen <= 1'b0;
      read_sr   <= '0;
      bit_cnt   <= '0;
      byte_out  <= '0;
      sync_n    <= 1'b1;
      br_cnt    <= '0;
    end else begin
      flux_d <= flux;
      sync_n <= ~(rd_mode & (read_sr == '1));
      // The strobe timer runs even with the motor off so a started strobe always finishes.
      if (cnt_wrap & soe)
        br_cnt <= BRW'(BR_LEN);
      else if (br_cnt != '0)
        br_cnt <= br_cnt - 1'b1;
      if (mode_chg) begin
        bit_cnt   <= '0;
        flux_seen <= 1'b0;
      end else begin
        if (bit_strobe) begin
          flux_seen <= 1'b0;
          bit_cnt   <= (rd_mode & sync_hit) ? 3'd0 : bit_cnt + 3'd1;
          if (rd_mode)
            read_sr <= sr_next;
          if (rd_mode & cnt_wrap)
            byte_out <= sr_next[7:0];
        end
        // An edge coinciding with the emission is kept for the next cell.
        if (resync)
          flux_seen <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_c1541_flux_shifter.sv
// Randomized bench: bit streams as flux pulses, expected bytes/SYNC computed from the bit list.
// Write path checked cell by cell from a buff_din history aligned on the byte strobes.
`timescale 1ns/1ps
module tb_c1541_flux_shifter;

  localparam int BR_LEN  = 16;
  localparam int HLEN    = 131072;
`ifdef C1541_WRITE_EN
  localparam logic RD_MODE = 1'b1;
`else
  localparam logic RD_MODE = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset, mtr, mode, soe, flux;
  logic [1:0] zone;
  logic [7:0] din_byte;
  logic [7:0] byte_out;
  logic       byte_ready_n, sync_n, buff_din, buff_we;

  int tests = 0;
  int fails = 0;

  bit         rb[$];
  bit         sync_e[$];
  logic [7:0] exp_q[$];
  logic [7:0] last_byte;

  int          cyc = 0;
  bit          hist[HLEN];
  logic        brn_prev = 1'b1;
  int          low_len = 0;
  bit          mon_wr = 1'b0;
  int          wr_falls[$];
  logic [31:0] mon_exp;

  c1541_flux_shifter #(.CLK_DIV(2), .BR_LEN(BR_LEN)) dut (
    .clk          (clk),
    .reset        (reset),
    .mtr          (mtr),
    .zone         (zone),
    .mode         (mode),
    .soe          (soe),
    .flux         (flux),
    .din_byte     (din_byte),
    .byte_out     (byte_out),
    .byte_ready_n (byte_ready_n),
    .sync_n       (sync_n),
    .buff_din     (buff_din),
    .buff_we      (buff_we)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Byte-ready monitor: read-mode strobes consume expected bytes, write-mode strobes are timestamped.
  always @(negedge clk) begin
    cyc++;
    hist[cyc % HLEN] = buff_din;
    if (reset) begin
      brn_prev = 1'b1;
      low_len  = 0;
    end else begin
      if (!byte_ready_n) begin
        if (brn_prev) begin
          if (mon_wr) begin
            wr_falls.push_back(cyc);
          end else begin
            if (exp_q.size() > 0) mon_exp = 32'(exp_q.pop_front());
            else mon_exp = 32'h100;
            check("rd_byte", 32'(byte_out), mon_exp);
          end
        end
        low_len++;
      end else if (!brn_prev) begin
        check("br_len", low_len, BR_LEN);
        low_len = 0;
      end
      brn_prev = byte_ready_n;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

  task automatic push_run(input bit v, input int n);
    for (int i = 0; i < n; i++) rb.push_back(v);
  endtask

  task automatic push_byte(input logic [7:0] b);
    for (int j = 7; j >= 0; j--) rb.push_back(b[j]);
  endtask

  task automatic gen_random(input int n);
    int r;
    rb.delete();
    for (int i = 0; i < int'($urandom_range(0, 5)); i++) rb.push_back(1'($urandom_range(0, 1)));
    push_run(1'b1, $urandom_range(10, 13));
    while (rb.size() < n) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        push_run(1'b1, $urandom_range(10, 12));
        rb.push_back(1'b0);
      end else if (r == 1) begin
        push_run(1'b0, $urandom_range(5, 20));
      end else begin
        push_byte(8'($urandom_range(0, 255)));
      end
    end
  endtask

  // SYNC = last ten cells all ones; a byte completes eight cells after the last SYNC cell or byte end.
  task automatic build_model(input bit soe_v);
    int         anchor;
    logic [7:0] v;
    bit         s;
    sync_e.delete();
    exp_q.delete();
    last_byte = 8'h00;
    anchor = -1;
    for (int i = 0; i < rb.size(); i++) begin
      s = (i >= 9);
      for (int k = i - 9; k <= i && s; k++) s = s & rb[k];
      sync_e.push_back(s);
      if (s) begin
        anchor = i;
      end else if (i - anchor == 8) begin
        v = 8'h00;
        for (int k = i - 7; k <= i; k++) v = {v[6:0], rb[k]};
        last_byte = v;
        if (soe_v) exp_q.push_back(v);
        anchor = i;
      end
    end
  endtask

  task automatic do_reset();
    mtr   = 1'b0;
    flux  = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_read(input int z, input bit soe_v, input int abort_at, input int pause_at);
    int p, q3;
    build_model(soe_v);
    zone = 2'(z);
    soe  = soe_v;
    mode = RD_MODE;
    do_reset();
    p  = 8 * (16 - z);
    q3 = (3 * p) / 4;
    mtr = 1'b1;
    @(negedge clk);
    for (int i = 0; i < rb.size(); i++) begin
      flux = rb[i];
      repeat (4) @(negedge clk);
      flux = 1'b0;
      repeat (q3 - 4) @(negedge clk);
      check("sync_n", sync_n, !sync_e[i]);
      if (i == abort_at) begin
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("rst_byte_out", byte_out, 0);
        check("rst_brn", byte_ready_n, 1);
        check("rst_sync_n", sync_n, 1);
        check("rst_buff_din", buff_din, 0);
        check("rst_buff_we", buff_we, 0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        mtr   = 1'b0;
        reset = 1'b0;
        return;
      end
      if (i == pause_at) begin
        mtr = 1'b0;
        repeat (500) @(negedge clk);
        check("pause_brn", byte_ready_n, 1);
        check("pause_sync", sync_n, !sync_e[i]);
        mtr = 1'b1;
      end
      repeat (p - q3) @(negedge clk);
    end
    check("rd_left", exp_q.size(), 0);
    check("rd_last", byte_out, last_byte);
    mtr = 1'b0;
  endtask

`ifdef C1541_WRITE_EN
  task automatic run_write(input int z, input int nbytes);
    logic [7:0] wb[$];
    int p, c, e, t;
    bit bv;
    zone = 2'(z);
    soe  = 1'b1;
    mode = 1'b1;
    do_reset();
    p = 8 * (16 - z);
    wb.push_back(8'hFF);
    wb.push_back(8'h55);
    while (wb.size() < nbytes) wb.push_back(8'($urandom_range(0, 255)));
    din_byte = wb[0];
    wr_falls.delete();
    mon_wr = 1'b1;
    mtr = 1'b1;
    @(negedge clk);
    mode = 1'b0;
    @(negedge clk);
    check("wr_we", buff_we, 1);
    check("wr_sync_n", sync_n, 1);
    for (int k = 0; k < nbytes; k++) begin
      t = 0;
      while (wr_falls.size() <= k && t < 10 * p) begin
        @(negedge clk);
        t++;
      end
      if (wr_falls.size() <= k) begin
        check("wr_timeout", wr_falls.size(), k + 1);
        break;
      end
      if (k + 1 < nbytes) din_byte = wb[k + 1];
    end
    repeat (p) @(negedge clk);
    for (int k = 0; k < wr_falls.size(); k++) begin
      c = wr_falls[k];
      if (k > 0) check("wr_gap", c - wr_falls[k - 1], 8 * p);
      for (int j = 0; j < 8; j++) begin
        bv = wb[k][7 - j];
        e  = c - (7 - j) * p;
        check("wr_din_on", hist[e % HLEN], bv);
        check("wr_din_end", hist[(e + p / 2 - 1) % HLEN], bv);
        check("wr_din_off", hist[(e + p / 2) % HLEN], 0);
      end
    end
    mon_wr = 1'b0;
    mtr = 1'b0;
    #1;
    check("wr_we_off", buff_we, 0);
    mode = 1'b1;
  endtask
`else
  task automatic run_nowrite();
    int highs;
    zone = 2'd3;
    mode = 1'b0;
    soe  = 1'b1;
    do_reset();
    mtr = 1'b1;
    highs = 0;
    for (int i = 0; i < 400; i++) begin
      flux = (i % 104) < 4;
      @(negedge clk);
      if (buff_din || buff_we) highs++;
    end
    check("nowr_buff", highs, 0);
    mtr = 1'b0;
  endtask
`endif

  initial begin
    reset = 1'b1; mtr = 1'b0; mode = 1'b1; soe = 1'b0;
    flux = 1'b0; zone = 2'd3; din_byte = 8'h00;
    @(negedge clk);
    check("init_byte_out", byte_out, 0);
    check("init_brn", byte_ready_n, 1);
    check("init_sync_n", sync_n, 1);
    check("init_buff_din", buff_din, 0);
    check("init_buff_we", buff_we, 0);

    rb.delete();
    push_run(1'b1, 12);
    push_byte(8'h52);
    push_byte(8'h55);
    run_read(3, 1'b1, -1, -1);

    rb.delete();
    push_run(1'b1, 4);
    push_run(1'b0, 20);
    push_byte(8'($urandom_range(0, 255)));
    run_read(0, 1'b1, -1, -1);

    for (int r = 0; r < 4; r++) begin
      gen_random(50);
      run_read($urandom_range(0, 3), r != 1, -1, (r == 2) ? 30 : -1);
    end

    gen_random(40);
    run_read(3, 1'b1, 21, -1);
    gen_random(40);
    run_read(2, 1'b1, -1, -1);

`ifdef C1541_WRITE_EN
    run_write(3, 6);
    run_write(1, 4);
`else
    run_nowrite();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
